// File: rtl/int_sequencer.sv
// Interrupt/reset entry sequencer: runs the six-cycle BRK-style stack push and
// vector fetch for reset, NMI and IRQ, with NMI edge capture and IRQ->NMI hijack.
module int_sequencer (
    input  logic clk,
    input  logic clr,
    input  logic irq,
    input  logic nmi,
    input  logic sync,
    input  logic idis,
    output logic busy,
    output logic brkinj,
    output logic rw,
    output logic spadloa,
    output logic spdec,
    output logic pchdboa,
    output logic pcldboa,
    output logic aoa,
    output logic dorwa,
    output logic veclo,
    output logic vechi,
    output logic setreset,
    output logic setirq,
    output logic setnmi,
    output logic sirirqdis
);

    typedef enum logic [2:0] {
        ST_RST, ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST, SRC_NMI, SRC_IRQ
    } src_t;

    state_t state;
    src_t   src;
    logic   nmipend;
    logic   nmiq;

    logic nmi_fall;
    logic final_nmi;

    assign nmi_fall  = nmiq & ~nmi;
    // Source that S5/S6 will use: a pending NMI takes over an IRQ before the vector fetch.
    assign final_nmi = (src == SRC_NMI) || (src == SRC_IRQ && nmipend);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_RST;
            src     <= SRC_RST;
            nmipend <= 1'b0;
            nmiq    <= 1'b1;
        end else begin
            nmiq <= nmi;

            case (state)
                ST_RST: begin
                    state <= ST_S1;
                    src   <= SRC_RST;
                end
                ST_IDLE: begin
                    if (sync && (nmipend || (!irq && !idis))) begin
                        state <= ST_S1;
                        src   <= nmipend ? SRC_NMI : SRC_IRQ;
                    end
                end
                ST_S1: state <= ST_S2;
                ST_S2: state <= ST_S3;
                ST_S3: state <= ST_S4;
                ST_S4: begin
                    state <= ST_S5;
                    if (final_nmi) src <= SRC_NMI;
                end
                ST_S5: state <= ST_S6;
                ST_S6: state <= ST_IDLE;
                default: state <= ST_RST;
            endcase

            // A fresh falling edge outranks the clear on S5 entry.
            if (nmi_fall)
                nmipend <= 1'b1;
            else if (state == ST_S4 && final_nmi)
                nmipend <= 1'b0;
        end
    end

    logic push;
    assign push = (src != SRC_RST);

    always_comb begin
        busy      = 1'b0;
        brkinj    = 1'b0;
        rw        = 1'b1;
        spadloa   = 1'b0;
        spdec     = 1'b0;
        pchdboa   = 1'b0;
        pcldboa   = 1'b0;
        aoa       = 1'b0;
        dorwa     = 1'b0;
        veclo     = 1'b0;
        vechi     = 1'b0;
        setreset  = 1'b0;
        setirq    = 1'b0;
        setnmi    = 1'b0;
        sirirqdis = 1'b0;

        case (state)
            ST_S1: begin
                busy   = 1'b1;
                brkinj = 1'b1;
            end
            ST_S2, ST_S3, ST_S4: begin
                // Reset walks SP down three times but never writes the stack.
                busy    = 1'b1;
                spadloa = 1'b1;
                spdec   = 1'b1;
                dorwa   = push;
                rw      = ~push;
                pchdboa = (state == ST_S2);
                pcldboa = (state == ST_S3);
                aoa     = (state == ST_S4);
            end
            ST_S5, ST_S6: begin
                busy      = 1'b1;
                veclo     = (state == ST_S5);
                vechi     = (state == ST_S6);
                sirirqdis = (state == ST_S6);
                setreset  = (src == SRC_RST);
                setirq    = (src == SRC_IRQ);
                setnmi    = (src == SRC_NMI);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: cycle-level reference model compared every cycle,
// plus directed scenarios with hand-counted expectations.
module tb_int_sequencer;

    logic clk = 1'b0;
    logic clr, irq, nmi, sync, idis;
    logic busy, brkinj, rw, spadloa, spdec, pchdboa, pcldboa, aoa, dorwa;
    logic veclo, vechi, setreset, setirq, setnmi, sirirqdis;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    int_sequencer dut (
        .clk(clk), .clr(clr), .irq(irq), .nmi(nmi), .sync(sync), .idis(idis),
        .busy(busy), .brkinj(brkinj), .rw(rw), .spadloa(spadloa), .spdec(spdec),
        .pchdboa(pchdboa), .pcldboa(pcldboa), .aoa(aoa), .dorwa(dorwa),
        .veclo(veclo), .vechi(vechi), .setreset(setreset), .setirq(setirq),
        .setnmi(setnmi), .sirirqdis(sirirqdis)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: position within a sequence (1..6, 0 = not running),
    // a reset-pending flag, the interrupt source and the NMI latch.
    localparam int M_RST = 0, M_NMI = 1, M_IRQ = 2;
    logic m_rst  = 1'b1;
    int   m_cyc  = 0;
    int   m_src  = M_RST;
    logic m_pend = 1'b0;
    logic m_prev = 1'b1;

    always @(posedge clk or negedge clr) begin : model
        logic fall;
        int   fsrc;
        if (!clr) begin
            m_rst  <= 1'b1;
            m_cyc  <= 0;
            m_src  <= M_RST;
            m_pend <= 1'b0;
            m_prev <= 1'b1;
        end else begin
            fall = m_prev && !nmi;
            fsrc = (m_cyc == 4 && m_src == M_IRQ && m_pend) ? M_NMI : m_src;
            m_prev <= nmi;
            if (m_rst) begin
                m_rst <= 1'b0;
                m_cyc <= 1;
                m_src <= M_RST;
            end else if (m_cyc == 0) begin
                if (sync && (m_pend || (!irq && !idis))) begin
                    m_cyc <= 1;
                    m_src <= m_pend ? M_NMI : M_IRQ;
                end
            end else begin
                m_cyc <= (m_cyc == 6) ? 0 : m_cyc + 1;
                m_src <= fsrc;
            end
            if (fall) m_pend <= 1'b1;
            else if (m_cyc == 4 && fsrc == M_NMI) m_pend <= 1'b0;
        end
    end

    function automatic logic [14:0] model_out();
        logic stk, wr;
        stk = (m_cyc >= 2 && m_cyc <= 4);
        wr  = stk && (m_src != M_RST);
        return {m_cyc != 0, m_cyc == 1, !wr, stk, stk, m_cyc == 2, m_cyc == 3,
                m_cyc == 4, wr, m_cyc == 5, m_cyc == 6,
                m_cyc >= 5 && m_src == M_RST, m_cyc >= 5 && m_src == M_IRQ,
                m_cyc >= 5 && m_src == M_NMI, m_cyc == 6};
    endfunction

    logic [14:0] dut_out;
    assign dut_out = {busy, brkinj, rw, spadloa, spdec, pchdboa, pcldboa, aoa,
                      dorwa, veclo, vechi, setreset, setirq, setnmi, sirirqdis};

    always @(negedge clk) check("outputs_vs_model", int'(dut_out), int'(model_out()));

    // Directed-scenario counters, accumulated one sample per clock.
    int c_busy, c_spdec, c_rw0, c_reset, c_irq, c_nmi, c_sirq, c_brk;
    logic [8:0] order;

    task automatic clear_counts();
        c_busy = 0; c_spdec = 0; c_rw0 = 0; c_reset = 0;
        c_irq = 0; c_nmi = 0; c_sirq = 0; c_brk = 0; order = '0;
    endtask

    task automatic samp();
        @(posedge clk); #1;
        c_busy  += int'(busy);
        c_spdec += int'(spdec);
        c_rw0   += int'(!rw);
        c_reset += int'(setreset);
        c_irq   += int'(setirq);
        c_nmi   += int'(setnmi);
        c_sirq  += int'(sirirqdis);
        c_brk   += int'(brkinj);
        if (pchdboa || pcldboa || aoa) order = {order[5:0], pchdboa, pcldboa, aoa};
    endtask

    task automatic samp_n(input int n);
        for (int i = 0; i < n; i++) samp();
    endtask

    initial begin
        clr = 1'b0; irq = 1'b1; nmi = 1'b1; sync = 1'b0; idis = 1'b1;
        clear_counts();

        // Power-on reset then the reset sequence
        samp_n(3);
        check("reset_busy", int'(busy), 0);
        check("reset_rw", int'(rw), 1);
        clr = 1'b1;
        clear_counts();
        samp();
        check("rst_s1_brkinj", int'(brkinj), 1);
        samp_n(9);
        check("rst_busy_cycles", c_busy, 6);
        check("rst_no_write", c_rw0, 0);
        check("rst_spdec_cycles", c_spdec, 3);
        check("rst_setreset_cycles", c_reset, 2);
        check("rst_sirq_cycles", c_sirq, 1);

        // IRQ sequence
        idis = 1'b0; irq = 1'b0; sync = 1'b1;
        clear_counts();
        samp();
        check("irq_brkinj_next", int'(brkinj), 1);
        sync = 1'b0; irq = 1'b1;
        samp_n(7);
        check("irq_write_cycles", c_rw0, 3);
        check("irq_push_order", int'(order), 9'b100_010_001);
        check("irq_setirq_cycles", c_irq, 2);
        check("irq_setnmi_cycles", c_nmi, 0);

        // Masked IRQ over 20 sync pulses
        idis = 1'b1; irq = 1'b0;
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            sync = 1'b1; samp();
            sync = 1'b0; samp();
        end
        check("masked_irq_busy", c_busy, 0);
        irq = 1'b1;

        // NMI edge while not at sync, then held low
        clear_counts();
        nmi = 1'b0;
        samp_n(3);
        check("nmi_waits_sync", c_busy, 0);
        sync = 1'b1; samp(); sync = 1'b0;
        check("nmi_start_busy", int'(busy), 1);
        samp_n(7);
        check("nmi1_setnmi_cycles", c_nmi, 2);
        check("nmi1_busy_cycles", c_busy, 6);
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            sync = 1'b1; samp();
            sync = 1'b0; samp();
        end
        check("nmi_held_no_retrigger", c_busy, 0);
        nmi = 1'b1; samp();
        nmi = 1'b0; samp();
        clear_counts();
        sync = 1'b1; samp(); sync = 1'b0;
        samp_n(7);
        check("nmi2_setnmi_cycles", c_nmi, 2);
        check("nmi2_busy_cycles", c_busy, 6);
        nmi = 1'b1; samp_n(2);

        // NMI hijacks an IRQ sequence during S3
        idis = 1'b0; irq = 1'b0; sync = 1'b1;
        clear_counts();
        samp(); sync = 1'b0; irq = 1'b1;
        samp_n(2);
        nmi = 1'b0;
        samp_n(5);
        check("hijack_setnmi", c_nmi, 2);
        check("hijack_setirq", c_irq, 0);
        nmi = 1'b1;
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            sync = 1'b1; samp();
            sync = 1'b0; samp();
        end
        check("hijack_no_followon", c_busy, 0);

        // Reset pulsed mid-sequence
        idis = 1'b0; irq = 1'b0; sync = 1'b1;
        samp(); sync = 1'b0; irq = 1'b1;
        samp_n(2);
        check("pre_clr_write", int'(rw), 0);
        clr = 1'b0; #1;
        check("clr_rw_immediate", int'(rw), 1);
        check("clr_busy_immediate", int'(busy), 0);
        samp_n(2);
        clr = 1'b1;
        clear_counts();
        samp_n(8);
        check("clr_reseq_setreset", c_reset, 2);
        check("clr_reseq_busy", c_busy, 6);
        check("clr_reseq_setirq", c_irq, 0);

        samp_n(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 clr  input  1  asynchronous, active-low reset.
REQ-004 irq  input  1  active-low, level-sensitive interrupt request.
REQ-005 nmi  input  1  active-low, edge-triggered non-maskable interrupt.
REQ-006 sync  input  1  high during an opcode-fetch cycle, i.e. an instruction boundary.
REQ-007 idis  input  1  status-register I flag; 1 masks irq.
REQ-008 busy  output  1  high while a sequence is in progress (states S1-S6).
REQ-009 brkinj  output  1  forces the instruction register to load BRK (00) instead of the fetched opcode.
REQ-010 rw  output  1  bus direction: 1 = read, 0 = write.
REQ-011 spadloa  output  1  stack pointer drives adl.
REQ-012 spdec  output  1  decrement stack pointer.
REQ-013 pchdboa  output  1  PCH drives db.
REQ-014 pcldboa  output  1  PCL drives db.
REQ-015 aoa  output  1  status register drives db.
REQ-016 dorwa  output  1  data output register write enable.
REQ-017 veclo  output  1  load PCL from the vector low byte.
REQ-018 vechi  output  1  load PCH from the vector high byte.
REQ-019 setreset / setirq / setnmi  output  1 each  one-hot vector select (FFFC / FFFE / FFFA).
REQ-020 sirirqdis  output  1  set the I flag.

Function
REQ-021 States: RST, IDLE, S1, S2, S3, S4, S5, S6.
REQ-022 Registers: state, src (RST/NMI/IRQ), nmipend, nmiq (previous nmi sample).
REQ-023 Outputs SHALL be decoded from registered state and src only (Moore), with no combinational path from any input.
REQ-024 nmi edge: nmipend SHALL set on any posedge where nmiq=1 and nmi=0; nmiq<=nmi on every edge.
REQ-025 nmi held low SHALL NOT retrigger; a new high-to-low transition is required.
REQ-026 IDLE->S1 SHALL occur only when sync=1 and (nmipend=1, or irq=0 with idis=0); src<=NMI if nmipend=1, else IRQ.
REQ-027 irq SHALL be sampled only at sync; if irq deasserts before sync, no sequence starts.
REQ-028 RST->S1 SHALL occur on the first posedge with clr high; src<=RST.
REQ-029 S1->S2->S3->S4->S5->S6->IDLE, one state per clock, unconditional, with sync ignored; a sequence lasts 6 cycles.
REQ-030 S1: busy=1, brkinj=1, rw=1 (dummy read).
REQ-031 S2: spadloa, pchdboa, dorwa, spdec=1, rw=0.
REQ-032 S3: spadloa, pcldboa, dorwa, spdec=1, rw=0.
REQ-033 S4: spadloa, aoa, dorwa, spdec=1, rw=0.
REQ-034 When src=RST, S2-S4 SHALL keep rw=1 and dorwa=0; spadloa and spdec still assert (three SP decrements, no writes).
REQ-035 S5: veclo=1, and the set<src> line is high.
REQ-036 S6: vechi=1, sirirqdis=1, and the set<src> line is high.
REQ-037 Hijack: if src=IRQ and nmipend=1 on the S4->S5 edge, src<=NMI, so S5 and S6 use setnmi.
REQ-038 nmipend SHALL clear on entry to S5 whenever the final src=NMI.
REQ-039 A new nmi edge on that same S5-entry edge SHALL win, leaving nmipend=1.
REQ-040 In IDLE and RST: busy and all strobes SHALL be 0 and rw=1.

Reset
REQ-041 clr=0 SHALL immediately force state=RST, src=RST, nmipend=0 and nmiq=1, and all outputs to IDLE values (rw=1), including mid-sequence.

Verification
REQ-042 clr low 3 cycles, then high -> busy high for exactly 6 cycles; rw stays 1; spdec high 3 cycles; setreset high in S5-S6; sirirqdis high in S6 only.
REQ-043 idis=0, irq=0 at sync=1 -> next cycle brkinj=1; rw=0 exactly in S2-S4, with pchdboa, pcldboa and aoa in that order; setirq high in S5-S6.
REQ-044 idis=1, irq=0 over 20 sync pulses -> busy stays 0.
REQ-045 nmi falls while sync=0 and then stays low -> exactly one sequence, started at the next sync, using setnmi; a second fall after nmi returns high -> a second sequence.
REQ-046 nmi falls during S3 of an IRQ sequence -> S5-S6 assert setnmi, not setirq; nmipend=0 afterwards; no follow-on sequence.
REQ-047 clr pulsed low during S3 -> rw=1 and busy=0 within the same cycle; after release, a reset sequence with setreset.
